// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared types for the fetch PC sequencer.
//   BasicTypes     : address width and the PC type.
//   FetchUnitTypes : instruction width and the sequencer state encoding.
package BasicTypes;
    localparam int ADDR_WIDTH = 32;
    typedef logic [ADDR_WIDTH-1:0] PC;
endpackage

package FetchUnitTypes;
    localparam int INSN_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,   // single cycle after reset
        REQ,    // instruction-memory request presented
        WAIT,   // one request outstanding
        HOLD    // instruction held for decode
    } PcSeqState;
endpackage

// File: rtl/fetch_pc_select.sv
// Next-PC selection for the fetch sequencer (purely combinational).
// Ports:
//   i_pc             current fetch PC
//   i_grant          an IMEM request is accepted this cycle
//   i_redirect_valid backend redirect this cycle
//   i_redirect_pc    redirect target
//   i_btb_hit        BTB hit for i_pc
//   i_btb_pc         BTB predicted target
//   o_load           the PC register loads o_next_pc this cycle
//   o_next_pc        selected next PC: redirect > BTB > pc+4
module fetch_pc_select
    import BasicTypes::*;
(
    input  PC    i_pc,
    input  logic i_grant,
    input  logic i_redirect_valid,
    input  PC    i_redirect_pc,
    input  logic i_btb_hit,
    input  PC    i_btb_pc,
    output logic o_load,
    output PC    o_next_pc
);

    // NOTE: every output gets a default at the top of always_comb, so no
    // path through the block can leave a value unassigned (no latch).
    always_comb begin
        o_load    = i_redirect_valid | i_grant;
        o_next_pc = i_pc + PC'(4);  // wraps modulo 2^ADDR_WIDTH
        if (i_redirect_valid) begin
            o_next_pc = i_redirect_pc;
        end else if (i_btb_hit) begin
            o_next_pc = i_btb_pc;
        end
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: owns the fetch PC, issues one IMEM request at a time,
// holds each fetched instruction for decode, and drops responses made stale
// by a backend redirect.
// Ports:
//   clk, rstN                       clock, async active-low reset
//   redirectValid, redirectPc       backend redirect (highest priority)
//   btbHit, btbPredictedPc          combinational BTB lookup on imemAddr
//   imemReq, imemAddr, imemGnt      IMEM request channel
//   imemRspValid, imemRspData       IMEM response channel
//   fetchValid, fetchPc, fetchInsn,
//   fetchPredPc, fetchReady         decode handshake
module fetch_pc_sequencer
    import BasicTypes::*;
    import FetchUnitTypes::*;
#(
    parameter PC RESET_PC = 32'h0000_0000
)(
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  redirectValid,
    input  PC                     redirectPc,
    input  logic                  btbHit,
    input  PC                     btbPredictedPc,
    output logic                  imemReq,
    output PC                     imemAddr,
    input  logic                  imemGnt,
    input  logic                  imemRspValid,
    input  logic [INSN_WIDTH-1:0] imemRspData,
    output logic                  fetchValid,
    output PC                     fetchPc,
    output logic [INSN_WIDTH-1:0] fetchInsn,
    output PC                     fetchPredPc,
    input  logic                  fetchReady
);

    PcSeqState             r_state;
    PcSeqState             w_next_state;
    logic                  r_stale;
    logic                  w_next_stale;
    PC                     r_pc;
    PC                     r_fetch_pc;
    PC                     r_fetch_pred_pc;
    logic [INSN_WIDTH-1:0] r_fetch_insn;
    logic                  w_grant;
    logic                  w_rsp_accept;
    logic                  w_pc_load;
    PC                     w_next_pc;

    // The grant gates the BTB/pc+4 update; a redirect loads the PC in any state.
    assign w_grant = (r_state == REQ) && imemGnt;

    fetch_pc_select u_pc_select (
        .i_pc             (r_pc),
        .i_grant          (w_grant),
        .i_redirect_valid (redirectValid),
        .i_redirect_pc    (redirectPc),
        .i_btb_hit        (btbHit),
        .i_btb_pc         (btbPredictedPc),
        .o_load           (w_pc_load),
        .o_next_pc        (w_next_pc)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_stale = r_stale;
        w_rsp_accept = 1'b0;
        case (r_state)
            IDLE: w_next_state = REQ;
            REQ: begin
                if (imemGnt) begin
                    w_next_state = WAIT;
                    // A redirect in the grant cycle orphans the accepted request.
                    if (redirectValid) w_next_stale = 1'b1;
                end
            end
            WAIT: begin
                if (imemRspValid) begin
                    w_next_stale = 1'b0;
                    if (r_stale || redirectValid) begin
                        w_next_state = REQ;    // drop the response
                    end else begin
                        w_next_state = HOLD;
                        w_rsp_accept = 1'b1;
                    end
                end else if (redirectValid) begin
                    w_next_stale = 1'b1;
                end
            end
            HOLD: begin
                // A redirect kills the held instruction whatever fetchReady says.
                if (redirectValid || fetchReady) w_next_state = REQ;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state         <= IDLE;
            r_stale         <= 1'b0;
            r_pc            <= RESET_PC;
            r_fetch_pc      <= RESET_PC;
            r_fetch_pred_pc <= RESET_PC;
            r_fetch_insn    <= '0;
        end else begin
            r_state <= w_next_state;
            r_stale <= w_next_stale;
            if (w_pc_load) r_pc <= w_next_pc;
            if (w_grant) begin
                r_fetch_pc      <= r_pc;
                r_fetch_pred_pc <= w_next_pc;
            end
            if (w_rsp_accept) r_fetch_insn <= imemRspData;
        end
    end

    // Pure decodes of registered state: no combinational path from inputs.
    assign imemReq     = (r_state == REQ);
    assign fetchValid  = (r_state == HOLD);
    assign imemAddr    = r_pc;
    assign fetchPc     = r_fetch_pc;
    assign fetchPredPc = r_fetch_pred_pc;
    assign fetchInsn   = r_fetch_insn;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer with RESET_PC = 0x100.
module tb_fetch_pc_sequencer;
    import BasicTypes::*;
    import FetchUnitTypes::*;

    logic                  clk = 1'b0;
    logic                  rstN;
    logic                  redirectValid;
    PC                     redirectPc;
    logic                  btbHit;
    PC                     btbPredictedPc;
    logic                  imemReq;
    PC                     imemAddr;
    logic                  imemGnt;
    logic                  imemRspValid;
    logic [INSN_WIDTH-1:0] imemRspData;
    logic                  fetchValid;
    PC                     fetchPc;
    logic [INSN_WIDTH-1:0] fetchInsn;
    PC                     fetchPredPc;
    logic                  fetchReady;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    fetch_pc_sequencer #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rstN           (rstN),
        .redirectValid  (redirectValid),
        .redirectPc     (redirectPc),
        .btbHit         (btbHit),
        .btbPredictedPc (btbPredictedPc),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemGnt        (imemGnt),
        .imemRspValid   (imemRspValid),
        .imemRspData    (imemRspData),
        .fetchValid     (fetchValid),
        .fetchPc        (fetchPc),
        .fetchInsn      (fetchInsn),
        .fetchPredPc    (fetchPredPc),
        .fetchReady     (fetchReady)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        redirectValid  = 1'b0;
        redirectPc     = '0;
        btbHit         = 1'b0;
        btbPredictedPc = '0;
        imemGnt        = 1'b0;
        imemRspValid   = 1'b0;
        imemRspData    = '0;
        fetchReady     = 1'b0;
    endtask

    // One full fetch starting in REQ: immediate grant, 1-cycle response,
    // immediate decode acceptance. Ends in the following REQ cycle.
    task automatic fetch_one(input PC addr, input logic btb, input PC bpc,
                             input PC pred, input logic [31:0] insn, input int valid_cyc);
        check("req", 32'(imemReq), 32'd1);
        check("req_addr", imemAddr, addr);
        imemGnt        = 1'b1;
        btbHit         = btb;
        btbPredictedPc = bpc;
        step();
        clear_inputs();
        check("wait_req", 32'(imemReq), 32'd0);
        check("wait_valid", 32'(fetchValid), 32'd0);
        imemRspValid = 1'b1;
        imemRspData  = insn;
        step();
        clear_inputs();
        check("hold_valid", 32'(fetchValid), 32'd1);
        if (valid_cyc >= 0) check("valid_cycle", cyc, valid_cyc);
        check("hold_pc", fetchPc, addr);
        check("hold_insn", fetchInsn, insn);
        check("hold_pred", fetchPredPc, pred);
        fetchReady = 1'b1;
        step();
        clear_inputs();
        check("after_ready_valid", 32'(fetchValid), 32'd0);
    endtask

    // A response is only legal while a request is outstanding (no req, no hold).
    always @(negedge clk) begin
        if (rstN && imemRspValid) check("rsp_outside_wait", 32'({imemReq, fetchValid}), 32'd0);
    end

    initial begin
        rstN = 1'b0;
        clear_inputs();
        step();
        check("rst_req", 32'(imemReq), 32'd0);
        check("rst_valid", 32'(fetchValid), 32'd0);
        check("rst_addr", imemAddr, 32'h100);
        check("rst_fetch_pc", fetchPc, 32'h100);
        check("rst_pred_pc", fetchPredPc, 32'h100);
        check("rst_insn", fetchInsn, 32'h0);

        // Release reset: this cycle is IDLE, the next is the first REQ (cycle 0).
        rstN = 1'b1;
        step();
        cyc = 0;
        fetch_one(32'h100, 1'b0, 32'h0, 32'h104, 32'hC0DE_0100, 2);
        fetch_one(32'h104, 1'b0, 32'h0, 32'h108, 32'hC0DE_0104, 5);
        fetch_one(32'h108, 1'b0, 32'h0, 32'h10C, 32'hC0DE_0108, 8);

        // Redirect while WAIT; the stale response arrives 3 cycles later.
        check("r3_addr", imemAddr, 32'h10C);
        imemGnt = 1'b1;
        step();
        clear_inputs();
        redirectValid = 1'b1;
        redirectPc    = 32'h400;
        step();
        clear_inputs();
        check("r3_stale_addr", imemAddr, 32'h400);
        check("r3_stale_req", 32'(imemReq), 32'd0);
        step();
        check("r3_wait_valid", 32'(fetchValid), 32'd0);
        step();
        imemRspValid = 1'b1;
        imemRspData  = 32'hBAD0_010C;
        step();
        clear_inputs();
        check("r3_drop_valid", 32'(fetchValid), 32'd0);
        check("r3_drop_req", 32'(imemReq), 32'd1);
        check("r3_drop_addr", imemAddr, 32'h400);
        check("r3_drop_insn", fetchInsn, 32'hC0DE_0108);
        fetch_one(32'h400, 1'b0, 32'h0, 32'h404, 32'hC0DE_0400, -1);

        // Redirect coincident with grant; BTB hit must be ignored.
        imemGnt        = 1'b1;
        redirectValid  = 1'b1;
        redirectPc     = 32'h400;
        btbHit         = 1'b1;
        btbPredictedPc = 32'h900;
        step();
        clear_inputs();
        check("r4_wait_req", 32'(imemReq), 32'd0);
        check("r4_wait_addr", imemAddr, 32'h400);
        imemRspValid = 1'b1;
        imemRspData  = 32'hBAD0_0404;
        step();
        clear_inputs();
        check("r4_drop_valid", 32'(fetchValid), 32'd0);
        check("r4_drop_insn", fetchInsn, 32'hC0DE_0400);
        fetch_one(32'h400, 1'b0, 32'h0, 32'h404, 32'hC0DE_2400, -1);

        // HOLD stall for 5 cycles, then redirect together with fetchReady.
        imemGnt = 1'b1;
        step();
        clear_inputs();
        imemRspValid = 1'b1;
        imemRspData  = 32'hC0DE_0404;
        step();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(fetchValid), 32'd1);
            check("stall_pc", fetchPc, 32'h404);
            check("stall_insn", fetchInsn, 32'hC0DE_0404);
            check("stall_pred", fetchPredPc, 32'h408);
            step();
        end
        redirectValid = 1'b1;
        redirectPc    = 32'h800;
        fetchReady    = 1'b1;
        step();
        clear_inputs();
        check("kill_valid", 32'(fetchValid), 32'd0);
        check("kill_req", 32'(imemReq), 32'd1);
        check("kill_addr", imemAddr, 32'h800);

        // Reset asserted mid-WAIT with a late response present.
        imemGnt = 1'b1;
        step();
        clear_inputs();
        rstN         = 1'b0;
        imemRspValid = 1'b1;
        imemRspData  = 32'hBAD0_0800;
        #1;
        check("mid_rst_req", 32'(imemReq), 32'd0);
        check("mid_rst_valid", 32'(fetchValid), 32'd0);
        check("mid_rst_addr", imemAddr, 32'h100);
        check("mid_rst_fetch_pc", fetchPc, 32'h100);
        check("mid_rst_pred_pc", fetchPredPc, 32'h100);
        check("mid_rst_insn", fetchInsn, 32'h0);
        step();
        step();
        clear_inputs();
        rstN = 1'b1;
        step();
        check("restart_valid", 32'(fetchValid), 32'd0);
        check("restart_insn", fetchInsn, 32'h0);
        fetch_one(32'h100, 1'b0, 32'h0, 32'h104, 32'hC0DE_0100, -1);

        // BTB hit at grant of 0x104.
        fetch_one(32'h104, 1'b1, 32'h200, 32'h200, 32'hC0DE_0104, -1);
        fetch_one(32'h200, 1'b0, 32'h0, 32'h204, 32'hC0DE_0200, -1);

        // Redirect in REQ without grant, then pc+4 wrap at the top of memory.
        redirectValid = 1'b1;
        redirectPc    = 32'hFFFF_FFFC;
        step();
        clear_inputs();
        fetch_one(32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 32'hC0DE_FFFC, -1);
        check("wrap_addr", imemAddr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
